dct_row_stage_pp: RTL and testbench
===================================

# dct_row_stage_pp

Parametrised, streaming successor to the fixed 8-point DCT stage. It applies a DIM-point integer 1D DCT-II to one row per cycle under a valid/ready handshake, and collects DIM result rows in a ping-pong transpose buffer. It then emits the block column by column, so a second instance can perform the column pass directly. It sits between the level-shift/block-fetch logic and the second DCT stage of the JPEG compression pipeline.

## Interface
- SIZE, 8, signed input sample width
- DIM, 8, transform length and block dimension; legal values are 4 and 8 only
- APPROX_BITS, 0, number of input LSBs zeroed when approx_en=1; legal range 0..SIZE-1
- SIZE_MULT, SIZE+6, width of each coefficient product
- SIZE_OUT, SIZE+$clog2(DIM), signed output word width
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  DIM x SIZE  unpacked array, one signed row sample per element
- in_valid  in  1  data_in holds a valid row
- in_ready  out  1  stage can accept a row this cycle
- approx_en  in  1  approximate mode, sampled with each accepted row
- data_out  out  DIM x SIZE_OUT  one transposed column; element j comes from result row j
- out_valid  out  1  data_out is valid
- out_ready  in  1  downstream accepts the column
- dct_stage_done  out  1  one-cycle pulse on the handshake of the last column of a block

## Operation
- Coefficients: C[k][n] = round(64·cos((2n+1)kπ/(2·DIM))).
  - Row k=0 is all 64.
  - DIM=8, row k=1: 63,53,36,12,-12,-36,-53,-63.
  - DIM=4, row k=1: 59,24,-24,-59.
  - Constant table; no multiplier sharing is required.
- Input masking: if approx_en=1, x_n has its low APPROX_BITS bits forced to 0 before multiplication.
- Per-output arithmetic: y_k = (Σ_n C[k][n]·x_n + 32) >>> 6.
  - Arithmetic shift; ties round toward +∞.
  - Result is saturated to the signed SIZE_OUT range. Saturation is unreachable for legal inputs but required.
- Ping-pong buffer:
  - Two banks, each DIM×DIM words of SIZE_OUT bits.
  - Each bank is in one of three states: EMPTY, FILLING or FULL.
  - Pointers wr_bank/wr_row and rd_bank/rd_col are all reset to 0.
- Write side (handshake = in_valid && in_ready):
  - in_ready = (state[wr_bank] != FULL) and the bank is not awaiting its last write.
  - An accepted row is registered into the product/sum pipeline register.
  - The row is written to bank[wr_bank] row wr_row on the next edge.
  - Accepting row 0 makes the bank FILLING.
  - Accepting row DIM-1 toggles wr_bank and wraps wr_row to 0. The bank becomes FULL on the edge its last row is written.
- Read side:
  - out_valid = (state[rd_bank] == FULL).
  - data_out[j] = bank[rd_bank][j][rd_col].
  - A handshake (out_valid && out_ready) increments rd_col.
  - On the handshake at rd_col=DIM-1: the bank goes EMPTY, rd_bank toggles, rd_col wraps to 0, and dct_stage_done pulses.
- Simultaneous events:
  - A write-side transition and a read-side transition on different banks in the same cycle both take effect.
  - A bank returning to EMPTY is seen by in_ready on the following cycle.
  - in_ready never depends combinationally on out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, dct_stage_done=0, data_out=0. All bank states are EMPTY and all pointers are 0. Buffer contents are don't-care but must be zero in simulation.
- A reset mid-block discards all partial and full blocks. Nothing is emitted afterwards until a new block of DIM rows has been accepted.
- Latency: first row accepted at edge t ⇒ out_valid is high after edge t+DIM when rows arrive back-to-back.
- Throughput: with in_valid and out_ready held high, one row is accepted and one column emitted every cycle indefinitely, with no bubbles once both banks are in use.
- Backpressure: with out_ready low, exactly 2·DIM rows are accepted, then in_ready stays low.
  - After the first column handshake of the drained bank, in_ready stays low until the DIM-th column handshake.
  - in_ready rises one cycle after that handshake.
- data_out and out_valid are stable while out_valid=1 and out_ready=0.
- approx_en and data_in are ignored in cycles without an input handshake.

## Test plan
- DC block, DIM=8, all 64 samples =10, approx_en=0 → column 0 = eight 80s; columns 1..7 all 0; dct_stage_done pulses once, on the 8th column.
- Impulse, DIM=8: row 0 = {100,0,…,0}, rows 1..7 zero → columns 0,1,2,4 give element 0 = 100, 98, 92, 70 and elements 1..7 = 0.
- Extremes, DIM=8, all samples −128 → column 0 all −1024 (no wrap); other columns 0. All samples 127 → column 0 all 1016.
- Approx mode: APPROX_BITS=2, approx_en=1, all samples 7 → column 0 all 32. The same block with approx_en=0 → all 56.
- Backpressure: stream 24 rows with out_ready=0 → in_ready falls after 16 accepted. Raise out_ready → 8 columns of block 0 emerge, then in_ready returns and rows 17–24 are accepted; 3 done pulses in total.
- Reset mid-block: accept 5 rows, assert rst for 1 cycle → out_valid stays 0. A fresh 8-row DC block of 10s then yields column 0 = eight 80s after 9 cycles.

Source files
------------

// File: rtl/dct_row_stage_pp.sv
// Streaming DIM-point integer DCT-II row stage with a ping-pong transpose
// buffer. It takes one row per accepted handshake and emits the finished
// block column by column, so that a second instance can run the column pass.
module dct_row_stage_pp #(
    parameter int SIZE        = 8,
    parameter int DIM         = 8,
    parameter int APPROX_BITS = 0,
    parameter int SIZE_MULT   = SIZE + 6,
    parameter int SIZE_OUT    = SIZE + $clog2(DIM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE-1:0]     data_in [DIM],
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                approx_en,
    output logic [SIZE_OUT-1:0] data_out [DIM],
    output logic                out_valid,
    input  logic                out_ready,
    output logic                dct_stage_done
);

    localparam int LOG_DIM = $clog2(DIM);
    localparam int SUM_W   = SIZE_MULT + LOG_DIM;

    localparam logic [LOG_DIM-1:0] LAST  = LOG_DIM'(DIM - 1);
    localparam logic [SIZE-1:0]    AMASK = {SIZE{1'b1}} << APPROX_BITS;

    localparam logic signed [SUM_W:0] RND_HALF = (SUM_W + 1)'(32);
    localparam logic signed [SUM_W:0] SAT_MAX  =
        $signed({{(SUM_W + 2 - SIZE_OUT){1'b0}}, {(SIZE_OUT - 1){1'b1}}});
    localparam logic signed [SUM_W:0] SAT_MIN  =
        $signed({{(SUM_W + 2 - SIZE_OUT){1'b1}}, {(SIZE_OUT - 1){1'b0}}});

    // round(64 * cos((2n+1) k pi / (2 DIM))), row-major by k
    localparam int COEF8 [64] = '{
         64,  64,  64,  64,  64,  64,  64,  64,
         63,  53,  36,  12, -12, -36, -53, -63,
         59,  24, -24, -59, -59, -24,  24,  59,
         53, -12, -63, -36,  36,  63,  12, -53,
         45, -45, -45,  45,  45, -45, -45,  45,
         36, -63,  12,  53, -53, -12,  63, -36,
         24, -59,  59, -24, -24,  59, -59,  24,
         12, -36,  53, -63,  63, -53,  36, -12
    };
    localparam int COEF4 [16] = '{
         64,  64,  64,  64,
         59,  24, -24, -59,
         45, -45, -45,  45,
         24, -59,  59, -24
    };

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_e;

    function automatic logic signed [SIZE_MULT-1:0] coef(input int k, input int n);
        int c;
        if (DIM == 8) c = COEF8[(k * 8 + n) & 63];
        else          c = COEF4[(k * 4 + n) & 15];
        return SIZE_MULT'(c);
    endfunction

    // (sum + 32) >>> 6, ties toward +inf, clamped to the signed output range
    function automatic logic signed [SIZE_OUT-1:0] rnd_sat(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W:0] r;
        r = ($signed({s[SUM_W-1], s}) + RND_HALF) >>> 6;
        if (r > SAT_MAX)      return SAT_MAX[SIZE_OUT-1:0];
        else if (r < SAT_MIN) return SAT_MIN[SIZE_OUT-1:0];
        else                  return r[SIZE_OUT-1:0];
    endfunction

    bank_state_e state_q [2];
    bank_state_e state_d [2];

    logic               wr_bank, rd_bank;
    logic [LOG_DIM-1:0] wr_row, rd_col;

    logic signed [SIZE-1:0]      xm;
    logic signed [SIZE_MULT-1:0] prod;
    logic signed [SUM_W-1:0]     sum_c  [DIM];

    logic                        vld_p0;
    logic                        bank_p0;
    logic [LOG_DIM-1:0]          row_p0;
    logic signed [SUM_W-1:0]     sum_p0 [DIM];

    logic signed [SIZE_OUT-1:0]  bank_mem [2][DIM][DIM];

    logic in_fire, out_fire, last_wr_p0, pend_last;

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_wr_p0 = vld_p0 && (row_p0 == LAST);
    // The bank whose final row is still in flight cannot take a new row 0.
    assign pend_last  = last_wr_p0 && (bank_p0 == wr_bank);

    assign in_ready       = (state_q[wr_bank] != BANK_FULL) && !pend_last;
    assign out_valid      = (state_q[rd_bank] == BANK_FULL);
    assign dct_stage_done = out_fire && (rd_col == LAST);

    // Constant-coefficient dot products of the (optionally masked) input row
    always_comb begin
        xm   = '0;
        prod = '0;
        for (int k = 0; k < DIM; k++) sum_c[k] = '0;
        for (int k = 0; k < DIM; k++) begin
            for (int n = 0; n < DIM; n++) begin
                xm       = $signed(approx_en ? (data_in[n] & AMASK) : data_in[n]);
                prod     = $signed({{(SIZE_MULT - SIZE){xm[SIZE-1]}}, xm}) * coef(k, n);
                sum_c[k] = sum_c[k] + $signed({{LOG_DIM{prod[SIZE_MULT-1]}}, prod});
            end
        end
    end

    // Pipeline valid plus write/read pointer control
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            wr_bank <= 1'b0;
            wr_row  <= '0;
            rd_bank <= 1'b0;
            rd_col  <= '0;
        end else begin
            vld_p0 <= in_fire;
            if (in_fire) begin
                if (wr_row == LAST) begin
                    wr_row  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if (out_fire) begin
                if (rd_col == LAST) begin
                    rd_col  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
        end
    end

    // Sum stage register: row results and their destination in the buffer
    always_ff @(posedge clk) begin
        if (in_fire) begin
            sum_p0  <= sum_c;
            bank_p0 <= wr_bank;
            row_p0  <= wr_row;
        end
    end

    // Bank state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Bank state transitions; fill, complete and drain always target distinct banks
    always_comb begin
        state_d = state_q;
        if (in_fire && (wr_row == '0)) state_d[wr_bank] = BANK_FILLING;
        if (last_wr_p0)                state_d[bank_p0] = BANK_FULL;
        if (dct_stage_done)            state_d[rd_bank] = BANK_EMPTY;
    end

    // Transpose buffer write: result row lands in row row_p0 of its bank
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++)
                        bank_mem[b][r][c] <= '0;
        end else if (vld_p0) begin
            for (int k = 0; k < DIM; k++)
                bank_mem[bank_p0][row_p0][k] <= rnd_sat(sum_p0[k]);
        end
    end

    // Column read: element j is coefficient rd_col of result row j
    always_comb begin
        for (int j = 0; j < DIM; j++) data_out[j] = bank_mem[rd_bank][j][rd_col];
    end

endmodule

// File: tb/tb_dct_row_stage_pp.sv
// Self-checking bench for dct_row_stage_pp (DIM=8, SIZE=8, APPROX_BITS=2).
module tb_dct_row_stage_pp;

    localparam int SIZE = 8;
    localparam int DIM  = 8;
    localparam int AB   = 2;
    localparam int SO   = SIZE + $clog2(DIM);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [SIZE-1:0] data_in [DIM];
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic            approx_en = 1'b0;
    logic [SO-1:0]   data_out [DIM];
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            dct_stage_done;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 1;
    int done_cnt = 0;

    int rowbuf [DIM];
    int blk_in [DIM][DIM];
    int cap    [DIM][DIM];
    bit cap_ap [DIM];
    int row_cnt = 0;
    int obs    [DIM][DIM];
    int obs_col = 0;
    int exp_q [$];
    bit last_q [$];

    dct_row_stage_pp #(
        .SIZE(SIZE), .DIM(DIM), .APPROX_BITS(AB)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .approx_en(approx_en), .data_out(data_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .dct_stage_done(dct_stage_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int model_coef(input int k, input int n);
        real a;
        a = real'((2 * n + 1) * k) * 3.141592653589793 / real'(2 * DIM);
        return $rtoi($floor(64.0 * $cos(a) + 0.5));
    endfunction

    function automatic int model_y(input int r, input int k);
        int s = 0;
        int x;
        int y;
        for (int n = 0; n < DIM; n++) begin
            x = cap[r][n];
            if (cap_ap[r]) x = x & ~((1 << AB) - 1);
            s += model_coef(k, n) * x;
        end
        y = (s + 32) >>> 6;
        if (y > (1 << (SO - 1)) - 1) y = (1 << (SO - 1)) - 1;
        if (y < -(1 << (SO - 1)))    y = -(1 << (SO - 1));
        return y;
    endfunction

    function automatic void push_block();
        for (int c = 0; c < DIM; c++) begin
            for (int j = 0; j < DIM; j++) exp_q.push_back(model_y(j, c));
            last_q.push_back(c == DIM - 1);
        end
    endfunction

    // Downstream ready pattern
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: capture accepted rows, compare emitted columns
    always @(negedge clk) begin : mon
        int e;
        bit ld;
        if (rst) begin
            row_cnt = 0;
            obs_col = 0;
            exp_q.delete();
            last_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                for (int n = 0; n < DIM; n++) cap[row_cnt][n] = $signed(data_in[n]);
                cap_ap[row_cnt] = approx_en;
                row_cnt++;
                if (row_cnt == DIM) begin
                    push_block();
                    row_cnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() < DIM) begin
                    check("column_expected", exp_q.size(), DIM);
                end else begin
                    for (int j = 0; j < DIM; j++) begin
                        e = exp_q.pop_front();
                        check($sformatf("col%0d_elem%0d", obs_col, j), $signed(data_out[j]), e);
                        obs[obs_col][j] = $signed(data_out[j]);
                    end
                    ld = last_q.pop_front();
                    check($sformatf("done_col%0d", obs_col), dct_stage_done, ld);
                    if (dct_stage_done) done_cnt++;
                    obs_col = (obs_col + 1) % DIM;
                end
            end else begin
                check("done_idle", dct_stage_done, 0);
            end
        end
    end

    task automatic drive_row(input bit ap);
        int waited = 0;
        for (int j = 0; j < DIM; j++) data_in[j] = SIZE'(rowbuf[j]);
        approx_en = ap;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        approx_en = 1'($urandom_range(0, 1));
        for (int j = 0; j < DIM; j++) data_in[j] = SIZE'($urandom_range(0, 255));
    endtask

    task automatic send_block(input int ap, input int gap_max);
        bit a;
        for (int r = 0; r < DIM; r++) begin
            for (int n = 0; n < DIM; n++) rowbuf[n] = blk_in[r][n];
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            a = (ap == 2) ? 1'($urandom_range(0, 1)) : 1'(ap);
            drive_row(a);
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < DIM; r++)
            for (int n = 0; n < DIM; n++) blk_in[r][n] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < DIM; r++)
            for (int n = 0; n < DIM; n++) blk_in[r][n] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    // DC block of 10s from an idle stage: latency and first column
    task automatic dc_latency(input string tag);
        fill_const(10);
        send_block(0, 0);
        check({tag, "_early"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, out_valid, 1);
        for (int j = 0; j < DIM; j++) check({tag, "_col0"}, $signed(data_out[j]), 80);
        wait_drain();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : main
        int cnt;
        int done0;
        for (int j = 0; j < DIM; j++) data_in[j] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", dct_stage_done, 0);
        for (int j = 0; j < DIM; j++) check("rst_data_out", data_out[j], 0);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // DC block
        dc_latency("dc");
        for (int c = 1; c < DIM; c++)
            for (int j = 0; j < DIM; j++) check("dc_ac_zero", obs[c][j], 0);

        // Impulse
        fill_const(0);
        blk_in[0][0] = 100;
        send_block(0, 0);
        wait_drain();
        check("imp_c0", obs[0][0], 100);
        check("imp_c1", obs[1][0], 98);
        check("imp_c2", obs[2][0], 92);
        check("imp_c4", obs[4][0], 70);
        check("imp_c1_e1", obs[1][1], 0);

        // Extremes
        fill_const(-128);
        send_block(0, 0);
        wait_drain();
        for (int j = 0; j < DIM; j++) check("neg_c0", obs[0][j], -1024);
        check("neg_c3", obs[3][0], 0);
        fill_const(127);
        send_block(0, 0);
        wait_drain();
        for (int j = 0; j < DIM; j++) check("pos_c0", obs[0][j], 1016);

        // Approximate mode
        fill_const(7);
        send_block(1, 0);
        wait_drain();
        check("approx_on", obs[0][0], 32);
        send_block(0, 0);
        wait_drain();
        check("approx_off", obs[0][0], 56);

        // Random data, random gaps and random downstream readiness
        rdy_mode = 2;
        repeat (3) begin
            fill_rand();
            send_block(2, 2);
        end
        wait_drain();

        // Continuous streaming
        rdy_mode = 1;
        repeat (4) begin
            fill_rand();
            send_block(2, 0);
        end
        wait_drain();

        // Backpressure: two blocks fill both banks, third stalls
        rdy_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        done0 = done_cnt;
        repeat (2) begin
            fill_rand();
            send_block(0, 0);
        end
        check("bp_in_ready_low", in_ready, 0);
        fill_rand();
        for (int n = 0; n < DIM; n++) data_in[n] = SIZE'(blk_in[0][n]);
        approx_en = 1'b0;
        in_valid  = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("bp_stall", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
        end
        rdy_mode = 1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
            if (out_valid && out_ready) cnt++;
        end
        check("bp_cols_before_ready", cnt, DIM);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int r = 1; r < DIM; r++) begin
            for (int n = 0; n < DIM; n++) rowbuf[n] = blk_in[r][n];
            drive_row(1'b0);
        end
        wait_drain();
        check("bp_done_pulses", done_cnt - done0, 3);

        // Reset in the middle of a block
        fill_rand();
        for (int r = 0; r < 5; r++) begin
            for (int n = 0; n < DIM; n++) rowbuf[n] = blk_in[r][n];
            drive_row(1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_dout", data_out[0], 0);
        repeat (12) begin
            @(posedge clk);
            #1;
            check("mid_rst_idle", out_valid, 0);
        end
        dc_latency("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
